// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle CPU control FSM (Moore decode, memory-wait qualified)
module multicycle_ctrl #(
  parameter int WAIT_ON_MEM = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_en,
  output logic       branch,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dest,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  state_t     cur;
  state_t     nxt;
  logic [5:0] op_q;
  logic       rdy;

  // With memory waiting disabled every access completes immediately
  assign rdy   = (WAIT_ON_MEM != 0) ? mem_ready : 1'b1;
  assign state = cur;
  assign pc_en = pc_write | (branch & zero);

  // State register; reset forces FETCH regardless of the clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // Opcode is captured once as DECODE exits so later opcode changes are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 op_q <= 6'h00;
    else if (cur == S_DECODE)   op_q <= opcode;
  end

  // Next-state and Moore output decode; pc_write/ir_write are gated by reset so
  // the FETCH decode shows no PC or IR update while the block is held in reset
  always_comb begin
    nxt        = cur;
    pc_write   = 1'b0;
    branch     = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dest   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = rdy & reset;
        ir_write  = rdy & reset;
        if (rdy) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:             nxt = S_EXEC_R;
          OP_ADDI:              nxt = S_EXEC_I;
          OP_LW, OP_LH, OP_LHU: nxt = S_MEM_ADDR;
          OP_SW:                nxt = S_MEM_ADDR;
          OP_BEQ:               nxt = S_BRANCH;
          default: begin
            nxt        = S_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (rdy) nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = rdy;
        if (rdy) nxt = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dest   = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       zero;
  logic       pc_write, pc_en, branch, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dest, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  logic       reset_w;
  logic       mem_ready_w;
  logic       pc_write_w, pc_en_w, branch_w, i_or_d_w, mem_read_w, mem_write_w, ir_write_w;
  logic       mem_to_reg_w, reg_dest_w, reg_write_w, alu_src_a_w, illegal_op_w, instr_done_w;
  logic [1:0] alu_src_b_w, alu_op_w, pc_source_w;
  logic [3:0] state_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_ON_MEM(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_en(pc_en), .branch(branch), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dest(reg_dest), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .illegal_op(illegal_op), .instr_done(instr_done),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .state(state)
  );

  multicycle_ctrl #(.WAIT_ON_MEM(0)) dut_nowait (
    .clk(clk), .reset(reset_w), .opcode(opcode), .mem_ready(mem_ready_w), .zero(zero),
    .pc_write(pc_write_w), .pc_en(pc_en_w), .branch(branch_w), .i_or_d(i_or_d_w),
    .mem_read(mem_read_w), .mem_write(mem_write_w), .ir_write(ir_write_w),
    .mem_to_reg(mem_to_reg_w), .reg_dest(reg_dest_w), .reg_write(reg_write_w),
    .alu_src_a(alu_src_a_w), .illegal_op(illegal_op_w), .instr_done(instr_done_w),
    .alu_src_b(alu_src_b_w), .alu_op(alu_op_w), .pc_source(pc_source_w), .state(state_w)
  );

  // flags: {mem_read, mem_write, i_or_d, reg_write, reg_dest, instr_done, pc_en, illegal_op}
  logic [7:0]  fl_act;
  logic [18:0] outs;
  assign fl_act = {mem_read, mem_write, i_or_d, reg_write, reg_dest, instr_done, pc_en, illegal_op};
  assign outs   = {pc_write, pc_en, branch, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                   reg_dest, reg_write, alu_src_a, illegal_op, instr_done, alu_src_b, alu_op, pc_source};

  typedef struct {
    logic [5:0] op;
    logic       mr;
    logic       z;
    logic [3:0] st;
    logic [7:0] fl;
    logic [1:0] sb;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;

  task automatic add(input logic [5:0] op, input logic mr, input logic z,
                     input logic [3:0] st, input logic [7:0] fl, input logic [1:0] sb);
    vt[nv].op = op; vt[nv].mr = mr; vt[nv].z = z;
    vt[nv].st = st; vt[nv].fl = fl; vt[nv].sb = sb;
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int NW = 6;
  logic [3:0] seq_w [NW];

  initial begin
    // lw, mem_ready=1 throughout
    add(6'h23, 1, 0, 4'd0, 8'b1000_0010, 2'b01);
    add(6'h23, 1, 0, 4'd1, 8'b0000_0000, 2'b11);
    add(6'h23, 1, 0, 4'd2, 8'b0000_0000, 2'b10);
    add(6'h23, 1, 0, 4'd3, 8'b1010_0000, 2'b00);
    add(6'h23, 1, 0, 4'd4, 8'b0001_0100, 2'b00);
    // R-type, opcode flips to sw during EXEC_R
    add(6'h00, 1, 0, 4'd0, 8'b1000_0010, 2'b01);
    add(6'h00, 1, 0, 4'd1, 8'b0000_0000, 2'b11);
    add(6'h2B, 1, 0, 4'd6, 8'b0000_0000, 2'b00);
    add(6'h2B, 1, 0, 4'd7, 8'b0001_1100, 2'b00);
    // addi
    add(6'h08, 1, 0, 4'd0, 8'b1000_0010, 2'b01);
    add(6'h08, 1, 0, 4'd1, 8'b0000_0000, 2'b11);
    add(6'h08, 1, 0, 4'd8, 8'b0000_0000, 2'b10);
    add(6'h08, 1, 0, 4'd9, 8'b0001_0100, 2'b00);
    // beq taken
    add(6'h04, 1, 1, 4'd0, 8'b1000_0010, 2'b01);
    add(6'h04, 1, 1, 4'd1, 8'b0000_0000, 2'b11);
    add(6'h04, 1, 1, 4'd10, 8'b0000_0110, 2'b00);
    // beq not taken
    add(6'h04, 1, 0, 4'd0, 8'b1000_0010, 2'b01);
    add(6'h04, 1, 0, 4'd1, 8'b0000_0000, 2'b11);
    add(6'h04, 1, 0, 4'd10, 8'b0000_0100, 2'b00);
    // illegal
    add(6'h3F, 1, 0, 4'd0, 8'b1000_0010, 2'b01);
    add(6'h3F, 1, 0, 4'd1, 8'b0000_0101, 2'b11);
    // sw with one FETCH wait and two MEM_WRITE waits
    add(6'h2B, 0, 0, 4'd0, 8'b1000_0000, 2'b01);
    add(6'h2B, 1, 0, 4'd0, 8'b1000_0010, 2'b01);
    add(6'h2B, 1, 0, 4'd1, 8'b0000_0000, 2'b11);
    add(6'h2B, 1, 0, 4'd2, 8'b0000_0000, 2'b10);
    add(6'h2B, 0, 0, 4'd5, 8'b0110_0000, 2'b00);
    add(6'h2B, 0, 0, 4'd5, 8'b0110_0000, 2'b00);
    add(6'h2B, 1, 0, 4'd5, 8'b0110_0100, 2'b00);
    // lh with one MEM_READ wait
    add(6'h21, 1, 0, 4'd0, 8'b1000_0010, 2'b01);
    add(6'h21, 1, 0, 4'd1, 8'b0000_0000, 2'b11);
    add(6'h21, 1, 0, 4'd2, 8'b0000_0000, 2'b10);
    add(6'h21, 0, 0, 4'd3, 8'b1010_0000, 2'b00);
    add(6'h21, 1, 0, 4'd3, 8'b1010_0000, 2'b00);
    add(6'h21, 1, 0, 4'd4, 8'b0001_0100, 2'b00);
    // lhu fetch, continues into the async-reset sequence
    add(6'h25, 1, 0, 4'd0, 8'b1000_0010, 2'b01);

    seq_w[0] = 4'd0; seq_w[1] = 4'd1; seq_w[2] = 4'd2;
    seq_w[3] = 4'd3; seq_w[4] = 4'd4; seq_w[5] = 4'd0;

    reset = 1'b0; reset_w = 1'b0;
    opcode = 6'h00; mem_ready = 1'b1; zero = 1'b1; mem_ready_w = 1'b0;

    // Held in reset: only the FETCH memory-read decode is visible
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_state", state, 4'd0);
    chk("reset_outs", outs, {13'b0000100000000, 2'b01, 2'b00, 2'b00});
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < nv; i++) begin
      opcode = vt[i].op; mem_ready = vt[i].mr; zero = vt[i].z;
      #1;
      chk($sformatf("vec%0d_state", i), state, vt[i].st);
      chk($sformatf("vec%0d_flags", i), fl_act, vt[i].fl);
      chk($sformatf("vec%0d_srcb", i), alu_src_b, vt[i].sb);
      if (vt[i].st == 4'd10) begin
        chk($sformatf("vec%0d_pc_source", i), pc_source, 2'b01);
        chk($sformatf("vec%0d_branch", i), branch, 1'b1);
      end
      @(negedge clk);
    end

    // Now in DECODE for lhu; walk to MEM_READ and stall there
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("stall_state", state, 4'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_state", state, 4'd0);
    chk("async_mem_read", mem_read, 1'b1);
    chk("async_i_or_d", i_or_d, 1'b0);
    chk("async_instr_done", instr_done, 1'b0);
    @(negedge clk);
    chk("rst_hold_state", state, 4'd0);
    chk("rst_hold_done", instr_done, 1'b0);
    reset = 1'b1;
    #1;
    chk("post_rst_pc_write", pc_write, 1'b0);
    @(negedge clk);
    #1;
    chk("post_rst_fetch_wait", state, 4'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_decode", state, 4'd1);

    // No-wait variant: lw proceeds with mem_ready held low
    opcode = 6'h23;
    @(negedge clk);
    reset_w = 1'b1;
    for (int i = 0; i < NW; i++) begin
      #1;
      chk($sformatf("nowait%0d_state", i), state_w, seq_w[i]);
      if (i == 0) chk("nowait_pc_write", pc_write_w, 1'b1);
      if (i == 4) chk("nowait_reg_write", {reg_write_w, mem_to_reg_w, instr_done_w}, 3'b111);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_ON_MEM, default 1, meaning: 1 = memory states hold until mem_ready, 0 = mem_ready ignored (treated as 1).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port opcode, input, 6 bits: instruction opcode field from the instruction register.
REQ-005 The block SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-006 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 The block SHALL have 1-bit outputs pc_write, pc_en, branch, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dest, reg_write, alu_src_a, illegal_op and instr_done.
REQ-008 The block SHALL have 2-bit outputs alu_src_b, alu_op and pc_source.
REQ-009 The block SHALL have output state, 4 bits: the current FSM state code.

Function
REQ-010 State codes SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-011 Outputs SHALL be decoded combinationally from state (Moore style), except pc_write, ir_write, pc_en and the memory-wait qualification; every output not listed for a state SHALL be 0.
REQ-012 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready; go to DECODE when mem_ready=1, else stay in FETCH.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; opcode SHALL be sampled into an internal register op_q at the DECODE exit edge.
REQ-014 DECODE transitions: 0x00 -> EXEC_R; 0x08 -> EXEC_I; 0x23, 0x21 or 0x25 -> MEM_ADDR; 0x2B -> MEM_ADDR; 0x04 -> BRANCH; any other opcode -> FETCH with illegal_op=1 and instr_done=1 during the DECODE cycle.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEM_WRITE if op_q=0x2B, else go to MEM_READ.
REQ-016 MEM_READ: mem_read=1, i_or_d=1; go to MEM_WB on mem_ready, else stay.
REQ-017 MEM_WB: reg_write=1, mem_to_reg=1, reg_dest=0, instr_done=1; go to FETCH.
REQ-018 MEM_WRITE: mem_write=1, i_or_d=1; instr_done=mem_ready; go to FETCH on mem_ready, else stay.
REQ-019 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; go to R_WB.
REQ-020 R_WB: reg_write=1, reg_dest=1, mem_to_reg=0, instr_done=1; go to FETCH.
REQ-021 EXEC_I (addi): alu_src_a=1, alu_src_b=10, alu_op=00; go to I_WB.
REQ-022 I_WB: reg_write=1, reg_dest=0, mem_to_reg=0, instr_done=1; go to FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, branch=1, instr_done=1; go to FETCH.
REQ-024 pc_en SHALL equal pc_write OR (branch AND zero), combinationally.
REQ-025 Instruction latencies with zero memory wait SHALL be: R-type 4, addi 4, lw/lh/lhu 5, sw 4, beq 3, illegal 2 cycles (FETCH through the last state).
REQ-026 Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE SHALL add exactly one cycle of latency, and the state's outputs SHALL be held constant while waiting.
REQ-027 With WAIT_ON_MEM=0, every state SHALL behave as if mem_ready=1.
REQ-028 Opcode changes outside the DECODE exit edge SHALL NOT affect any transition.

Reset
REQ-029 While reset=0, state SHALL be FETCH and op_q SHALL be 0x00, asynchronously and independent of clk.
REQ-030 During reset, all outputs SHALL be 0 except the FETCH decode: mem_read=1, alu_src_b=01, and pc_write, ir_write and pc_en SHALL be 0.
REQ-031 Reset asserted in any state, including mid memory-wait, SHALL abandon the instruction; instr_done SHALL NOT pulse for it.
REQ-032 After reset deasserts, the first rising edge SHALL evaluate the FETCH transition.

Verification
REQ-033 Bench scenario: opcode=0x23, mem_ready=1 throughout -> state sequence 0,1,2,3,4,0; reg_write=mem_to_reg=1 only in state 4; instr_done pulses once.
REQ-034 Bench scenario: opcode=0x2B, mem_ready low for 2 cycles in MEM_WRITE -> state 5 held 3 cycles with mem_write=1; instr_done only on the third cycle.
REQ-035 Bench scenario: opcode=0x04 with zero=1, then with zero=0 -> pc_en=1 in BRANCH for the first case, 0 for the second; pc_source=01 in both.
REQ-036 Bench scenario: opcode=0x3F -> sequence 0,1,0 with illegal_op=1 in DECODE; no reg_write or mem_write is ever asserted.
REQ-037 Bench scenario: opcode=0x00, with opcode changed to 0x2B during EXEC_R -> sequence 0,1,6,7,0 with reg_dest=1 in R_WB.
REQ-038 Bench scenario: reset pulled low mid-MEM_READ, asynchronously between clock edges -> state=0 immediately; mem_read=1, i_or_d=0, instr_done=0.
